// File: rtl/fb_rect_fill_if.sv
// Request and pixel-RAM write bundle for the rectangle filler.
// master drives the request and wr_ready; slave is the filler itself.
interface fb_rect_fill_if;
   logic        start;
   logic [9:0]  x0;
   logic [9:0]  y0;
   logic [9:0]  w;
   logic [9:0]  h;
   logic [11:0] color;
   logic        wr_ready;
   logic        wr_en;
   logic [9:0]  wr_row;
   logic [9:0]  wr_col;
   logic [11:0] wr_data;
   logic        busy;
   logic        done;

   modport master (
      output start, x0, y0, w, h, color, wr_ready,
      input  wr_en, wr_row, wr_col, wr_data, busy, done
   );

   modport slave (
      input  start, x0, y0, w, h, color, wr_ready,
      output wr_en, wr_row, wr_col, wr_data, busy, done
   );
endinterface

// File: rtl/fb_rect_fill.sv
// Fills a screen-clipped rectangle in pixel RAM, one row-major write per accepted cycle.
// Every output is a register, so the first write appears the cycle after start is seen.
module fb_rect_fill #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input logic          clk,
   input logic          rst,
   fb_rect_fill_if.slave bus_io
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

   localparam logic [10:0] HRes = 11'(H_RES);
   localparam logic [10:0] VRes = 11'(V_RES);

   state_e      state_q, state_d;
   logic [9:0]  x0_q, x0_d;
   logic [9:0]  xEnd_q, xEnd_d;
   logic [9:0]  yEnd_q, yEnd_d;
   logic [9:0]  row_q, row_d;
   logic [9:0]  col_q, col_d;
   logic [11:0] data_q, data_d;
   logic        wrEn_q, wrEn_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [10:0] xSum, ySum;
   logic [10:0] xLim, yLim;
   logic [9:0]  xEndNew, yEndNew;
   logic        startValid;
   logic        accept;

   // Last column/row, in 11 bits so x0+w past 1023 still clips correctly.
   always_comb begin
      xSum       = {1'b0, bus_io.x0} + {1'b0, bus_io.w};
      ySum       = {1'b0, bus_io.y0} + {1'b0, bus_io.h};
      xLim       = (xSum > HRes) ? HRes : xSum;
      yLim       = (ySum > VRes) ? VRes : ySum;
      xEndNew    = 10'(xLim - 11'd1);
      yEndNew    = 10'(yLim - 11'd1);
      startValid = (bus_io.w != 10'd0) && (bus_io.h != 10'd0) &&
                   ({1'b0, bus_io.x0} < HRes) && ({1'b0, bus_io.y0} < VRes);
      accept     = wrEn_q && bus_io.wr_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x0_q    <= '0;
         xEnd_q  <= '0;
         yEnd_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         data_q  <= '0;
         wrEn_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         xEnd_q  <= xEnd_d;
         yEnd_q  <= yEnd_d;
         row_q   <= row_d;
         col_q   <= col_d;
         data_q  <= data_d;
         wrEn_q  <= wrEn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Without an accept everything holds, which keeps a stalled write stable.
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      xEnd_d  = xEnd_q;
      yEnd_d  = yEnd_q;
      row_d   = row_q;
      col_d   = col_q;
      data_d  = data_q;
      wrEn_d  = wrEn_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            wrEn_d = 1'b0;
            busy_d = 1'b0;
            if (bus_io.start) begin
               if (startValid) begin
                  state_d = FILL;
                  x0_d    = bus_io.x0;
                  xEnd_d  = xEndNew;
                  yEnd_d  = yEndNew;
                  row_d   = bus_io.y0;
                  col_d   = bus_io.x0;
                  data_d  = bus_io.color;
                  wrEn_d  = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end

         FILL: begin
            if (accept) begin
               if (col_q == xEnd_q) begin
                  if (row_q == yEnd_q) begin
                     state_d = DONE;
                     wrEn_d  = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     col_d = x0_q;
                     row_d = row_q + 10'd1;
                  end
               end else begin
                  col_d = col_q + 10'd1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            wrEn_d  = 1'b0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            wrEn_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus_io.wr_en   = wrEn_q;
   assign bus_io.wr_row  = row_q;
   assign bus_io.wr_col  = col_q;
   assign bus_io.wr_data = data_q;
   assign bus_io.busy    = busy_q;
   assign bus_io.done    = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: each task drives one scenario and checks hand-computed values.
// Outputs are sampled 1 time unit after each rising edge.
module tb_fb_rect_fill;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   fb_rect_fill_if bus ();

   fb_rect_fill #(.H_RES(640), .V_RES(480)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setRequest(input int x, input int y, input int ww, input int hh,
                             input logic [11:0] c);
      bus.x0    = 10'(x);
      bus.y0    = 10'(y);
      bus.w     = 10'(ww);
      bus.h     = 10'(hh);
      bus.color = c;
   endtask

   // Leaves the sim at cycle t+1, the first cycle a write can be visible.
   task automatic applyStart(input int x, input int y, input int ww, input int hh,
                             input logic [11:0] c);
      setRequest(x, y, ww, hh, c);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_ready = 1'b1;
      setRequest(1, 1, 2, 2, 12'hFFF);
      bus.start = 1'b1;
      tick();
      tick();
      compared++;
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ctrl got en=%b busy=%b done=%b want 0/0/0",
                  bus.wr_en, bus.busy, bus.done);
      end
      compared++;
      if (bus.wr_row !== 10'd0 || bus.wr_col !== 10'd0 || bus.wr_data !== 12'h000) begin
         mismatched++;
         $display("[TB] FAIL reset_addr got row=%0d col=%0d data=%h want 0/0/000",
                  bus.wr_row, bus.wr_col, bus.wr_data);
      end
      bus.start = 1'b0;
      rst = 1'b0;
      tick();
      compared++;
      if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_priority got busy=%b en=%b want 0/0", bus.busy, bus.wr_en);
      end
   endtask

   task automatic test_basic();
      int expRow[4];
      int expCol[4];
      expRow = '{20, 20, 21, 21};
      expCol = '{10, 11, 10, 11};
      bus.wr_ready = 1'b1;
      applyStart(10, 20, 2, 2, 12'h00F);
      for (int k = 0; k < 4; k++) begin
         compared++;
         if (bus.wr_en !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
             bus.wr_row !== 10'(expRow[k]) || bus.wr_col !== 10'(expCol[k]) ||
             bus.wr_data !== 12'h00F) begin
            mismatched++;
            $display("[TB] FAIL basic_write%0d got en=%b busy=%b done=%b (%0d,%0d) %h want 1/1/0 (%0d,%0d) 00f",
                     k, bus.wr_en, bus.busy, bus.done, bus.wr_row, bus.wr_col, bus.wr_data,
                     expRow[k], expCol[k]);
         end
         tick();
      end
      compared++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_done got done=%b busy=%b en=%b want 1/0/0",
                  bus.done, bus.busy, bus.wr_en);
      end
      tick();
      compared++;
      if (bus.done !== 1'b0 || bus.wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_done_pulse got done=%b en=%b want 0/0", bus.done, bus.wr_en);
      end
   endtask

   task automatic test_clip();
      bus.wr_ready = 1'b1;
      applyStart(638, 479, 5, 5, 12'hABC);
      compared++;
      if (bus.wr_en !== 1'b1 || bus.wr_row !== 10'd479 || bus.wr_col !== 10'd638 ||
          bus.wr_data !== 12'hABC) begin
         mismatched++;
         $display("[TB] FAIL clip_first got en=%b (%0d,%0d) %h want 1 (479,638) abc",
                  bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data);
      end
      tick();
      compared++;
      if (bus.wr_en !== 1'b1 || bus.wr_row !== 10'd479 || bus.wr_col !== 10'd639) begin
         mismatched++;
         $display("[TB] FAIL clip_second got en=%b (%0d,%0d) want 1 (479,639)",
                  bus.wr_en, bus.wr_row, bus.wr_col);
      end
      tick();
      compared++;
      if (bus.done !== 1'b1 || bus.wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL clip_done got done=%b en=%b want 1/0", bus.done, bus.wr_en);
      end
      tick();
   endtask

   task automatic test_stall();
      int nAcc = 0;
      int accCol[8];
      int doneSeen = 0;
      for (int k = 0; k < 8; k++) accCol[k] = -1;
      bus.wr_ready = 1'b1;
      applyStart(100, 50, 4, 1, 12'h0F0);
      for (int c = 1; c <= 20 && doneSeen == 0; c++) begin
         bus.wr_ready = !(c >= 2 && c <= 4);
         if (c >= 2 && c <= 5) begin
            compared++;
            if (bus.wr_en !== 1'b1 || bus.wr_row !== 10'd50 || bus.wr_col !== 10'd101 ||
                bus.wr_data !== 12'h0F0) begin
               mismatched++;
               $display("[TB] FAIL stall_hold c=%0d got en=%b (%0d,%0d) %h want 1 (50,101) 0f0",
                        c, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data);
            end
         end
         if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
            if (nAcc < 8) accCol[nAcc] = int'(bus.wr_col);
            nAcc++;
         end
         if (bus.done === 1'b1) doneSeen = 1;
         tick();
      end
      bus.wr_ready = 1'b1;
      compared++;
      if (nAcc != 4 || doneSeen != 1) begin
         mismatched++;
         $display("[TB] FAIL stall_count got accepts=%0d done=%0d want 4/1", nAcc, doneSeen);
      end
      for (int k = 0; k < 4; k++) begin
         compared++;
         if (accCol[k] != 100 + k) begin
            mismatched++;
            $display("[TB] FAIL stall_order%0d got col=%0d want %0d", k, accCol[k], 100 + k);
         end
      end
   endtask

   task automatic test_zero_size();
      bus.wr_ready = 1'b1;
      applyStart(30, 30, 0, 3, 12'h123);
      compared++;
      if (bus.done !== 1'b1 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL zero_w got done=%b en=%b busy=%b want 1/0/0",
                  bus.done, bus.wr_en, bus.busy);
      end
      tick();
      compared++;
      if (bus.done !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL zero_w_after got done=%b en=%b busy=%b want 0/0/0",
                  bus.done, bus.wr_en, bus.busy);
      end
      applyStart(640, 5, 4, 4, 12'h321);
      compared++;
      if (bus.done !== 1'b1 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL off_screen got done=%b en=%b busy=%b want 1/0/0",
                  bus.done, bus.wr_en, bus.busy);
      end
      tick();
   endtask

   task automatic test_reset_mid_fill();
      int activity = 0;
      int nAcc = 0;
      int doneSeen = 0;
      int lastRow = -1;
      int lastCol = -1;
      bus.wr_ready = 1'b1;
      applyStart(5, 7, 4, 4, 12'h555);
      tick();
      tick();
      compared++;
      if (bus.wr_col !== 10'd7 || bus.wr_row !== 10'd7) begin
         mismatched++;
         $display("[TB] FAIL abort_third got (%0d,%0d) want (7,7)", bus.wr_row, bus.wr_col);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      compared++;
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_next got en=%b busy=%b done=%b want 0/0/0",
                  bus.wr_en, bus.busy, bus.done);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.wr_en !== 1'b0 || bus.done !== 1'b0) activity++;
      end
      compared++;
      if (activity != 0) begin
         mismatched++;
         $display("[TB] FAIL abort_quiet got active_cycles=%0d want 0", activity);
      end
      applyStart(5, 7, 4, 4, 12'h777);
      compared++;
      if (bus.wr_en !== 1'b1 || bus.wr_row !== 10'd7 || bus.wr_col !== 10'd5 ||
          bus.wr_data !== 12'h777) begin
         mismatched++;
         $display("[TB] FAIL restart_first got en=%b (%0d,%0d) %h want 1 (7,5) 777",
                  bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data);
      end
      for (int c = 0; c < 40 && doneSeen == 0; c++) begin
         if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
            nAcc++;
            lastRow = int'(bus.wr_row);
            lastCol = int'(bus.wr_col);
         end
         if (bus.done === 1'b1) doneSeen = 1;
         tick();
      end
      compared++;
      if (nAcc != 16 || doneSeen != 1 || lastRow != 10 || lastCol != 8) begin
         mismatched++;
         $display("[TB] FAIL restart_full got accepts=%0d done=%0d last=(%0d,%0d) want 16/1 (10,8)",
                  nAcc, doneSeen, lastRow, lastCol);
      end
   endtask

   task automatic test_ignore_start();
      int nAcc = 0;
      int doneCount = 0;
      int badData = 0;
      int accCol[4];
      for (int k = 0; k < 4; k++) accCol[k] = -1;
      bus.wr_ready = 1'b1;
      applyStart(0, 0, 3, 1, 12'h111);
      setRequest(50, 60, 2, 2, 12'h222);
      for (int c = 1; c <= 10; c++) begin
         bus.start = (c == 1 || c == 2 || c == 4);
         if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
            if (nAcc < 4) accCol[nAcc] = int'(bus.wr_col);
            if (bus.wr_data !== 12'h111) badData++;
            nAcc++;
         end
         if (bus.done === 1'b1) doneCount++;
         tick();
      end
      bus.start = 1'b0;
      compared++;
      if (nAcc != 3 || doneCount != 1 || badData != 0) begin
         mismatched++;
         $display("[TB] FAIL ignore_start got accepts=%0d dones=%0d bad_data=%0d want 3/1/0",
                  nAcc, doneCount, badData);
      end
      compared++;
      if (accCol[0] != 0 || accCol[1] != 1 || accCol[2] != 2) begin
         mismatched++;
         $display("[TB] FAIL ignore_order got cols=%0d,%0d,%0d want 0,1,2",
                  accCol[0], accCol[1], accCol[2]);
      end
   endtask

   task automatic test_back_to_back();
      bus.wr_ready = 1'b1;
      applyStart(639, 0, 1, 1, 12'hF00);
      compared++;
      if (bus.wr_en !== 1'b1 || bus.wr_row !== 10'd0 || bus.wr_col !== 10'd639) begin
         mismatched++;
         $display("[TB] FAIL b2b_first got en=%b (%0d,%0d) want 1 (0,639)",
                  bus.wr_en, bus.wr_row, bus.wr_col);
      end
      tick();
      tick();
      applyStart(0, 479, 1, 1, 12'h0A0);
      compared++;
      if (bus.wr_en !== 1'b1 || bus.wr_row !== 10'd479 || bus.wr_col !== 10'd0 ||
          bus.wr_data !== 12'h0A0) begin
         mismatched++;
         $display("[TB] FAIL b2b_second got en=%b (%0d,%0d) %h want 1 (479,0) 0a0",
                  bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data);
      end
      tick();
      compared++;
      if (bus.done !== 1'b1 || bus.wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_done got done=%b en=%b want 1/0", bus.done, bus.wr_en);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.wr_ready = 1'b1;
      setRequest(0, 0, 0, 0, 12'h000);
      #1;
      test_reset();
      test_basic();
      test_clip();
      test_stall();
      test_zero_size();
      test_reset_mid_fill();
      test_ignore_start();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
